// File: rtl/lcd_char_writer.sv
// lcd_char_writer
//   Pulls characters from a text-grid source by scanning column/row and
//   streams them into an HD44780-compatible character LCD in 8-bit mode.
//   After power-up it issues function set (38), display on (0C), clear (01)
//   and entry mode (06). It then loops forever: set DDRAM address for a row,
//   then write each character of that row.
//
// Ports
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   column      column address to the character source
//   row         row address to the character source
//   character   ASCII from the source, combinational in column/row
//   lcd_e       LCD enable strobe
//   lcd_rs      LCD register select (0 command, 1 data)
//   lcd_rw      LCD read/write, always 0 (write only)
//   lcd_data    LCD DB[7:0]
//   frame_done  one-cycle pulse after the last cell of the last row
//   debug_state {step, phase} of the controller, for observation only
//
// There is no valid/ready handshake here. The character source is a pure
// combinational lookup: column/row are held stable for a full FETCH cycle,
// and `character` is sampled only at the end of that cycle.
module lcd_char_writer #(
  parameter int COLUMNS         = 16,
  parameter int ROWS            = 2,
  parameter int POWER_ON_CYCLES = 2_500_000,
  parameter int SETUP_CYCLES    = 4,
  parameter int PULSE_CYCLES    = 25,
  parameter int HOLD_CYCLES     = 4,
  parameter int EXEC_CYCLES     = 2_500,
  parameter int CLEAR_CYCLES    = 100_000
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [6:0] column,
  output logic [5:0] row,
  input  logic [6:0] character,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       frame_done,
  output logic [5:0] debug_state
);

  localparam int MAX_WAIT = (POWER_ON_CYCLES > CLEAR_CYCLES) ? POWER_ON_CYCLES : CLEAR_CYCLES;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0] POWER_LAST = CW'(POWER_ON_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] EXEC_LAST  = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [6:0]    COL_LAST   = 7'(COLUMNS - 1);
  localparam logic [5:0]    ROW_LAST   = 6'(ROWS - 1);

  // phase: where the write engine is. step: which write is in flight.
  typedef enum logic [2:0] {
    POWER_WAIT = 3'd0,
    SETUP      = 3'd1,
    PULSE      = 3'd2,
    HOLD       = 3'd3,
    WAIT       = 3'd4,
    FETCH      = 3'd5
  } phase_t;

  typedef enum logic [2:0] {
    INIT_FUNC  = 3'd0,
    INIT_DISP  = 3'd1,
    INIT_CLEAR = 3'd2,
    INIT_ENTRY = 3'd3,
    SET_ADDR   = 3'd4,
    WRITE_CHAR = 3'd5
  } step_t;

  phase_t        phase, phase_next;
  step_t         step, step_next;
  logic [CW-1:0] count, count_next;
  logic [6:0]    column_next;
  logic [5:0]    row_next;
  logic [7:0]    data_next;
  logic          rs_next;
  logic          frame_done_next;
  logic          is_clear;

  function automatic logic [7:0] row_base(input logic [5:0] r);
    case (r)
      6'd0:    row_base = 8'h00;
      6'd1:    row_base = 8'h40;
      6'd2:    row_base = 8'(COLUMNS);
      default: row_base = 8'(8'h40 + COLUMNS);
    endcase
  endfunction

  // Clear-display needs the long execution wait.
  assign is_clear    = !lcd_rs && (lcd_data == 8'h01);
  assign lcd_rw      = 1'b0;
  assign debug_state = {step, phase};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= POWER_WAIT;
      step       <= INIT_FUNC;
      count      <= '0;
      column     <= '0;
      row        <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      phase      <= phase_next;
      step       <= step_next;
      count      <= count_next;
      column     <= column_next;
      row        <= row_next;
      // E is registered so it is high exactly while the engine is in PULSE.
      lcd_e      <= (phase_next == PULSE);
      lcd_rs     <= rs_next;
      lcd_data   <= data_next;
      frame_done <= frame_done_next;
    end
  end

  // RS/DB are only ever loaded on entry to SETUP, so they stay frozen
  // through SETUP, PULSE and HOLD without any extra qualification.
  always_comb begin
    phase_next      = phase;
    step_next       = step;
    count_next      = count + 1'b1;
    column_next     = column;
    row_next        = row;
    data_next       = lcd_data;
    rs_next         = lcd_rs;
    frame_done_next = 1'b0;

    case (phase)
      POWER_WAIT: begin
        if (count == POWER_LAST) begin
          count_next = '0;
          phase_next = SETUP;
          step_next  = INIT_FUNC;
          rs_next    = 1'b0;
          data_next  = 8'h38;
        end
      end
      SETUP: begin
        if (count == SETUP_LAST) begin
          count_next = '0;
          phase_next = PULSE;
        end
      end
      PULSE: begin
        if (count == PULSE_LAST) begin
          count_next = '0;
          phase_next = HOLD;
        end
      end
      HOLD: begin
        if (count == HOLD_LAST) begin
          count_next = '0;
          phase_next = WAIT;
        end
      end
      WAIT: begin
        if (count == (is_clear ? CLEAR_LAST : EXEC_LAST)) begin
          count_next = '0;
          case (step)
            INIT_FUNC: begin
              step_next  = INIT_DISP;
              phase_next = SETUP;
              rs_next    = 1'b0;
              data_next  = 8'h0C;
            end
            INIT_DISP: begin
              step_next  = INIT_CLEAR;
              phase_next = SETUP;
              rs_next    = 1'b0;
              data_next  = 8'h01;
            end
            INIT_CLEAR: begin
              step_next  = INIT_ENTRY;
              phase_next = SETUP;
              rs_next    = 1'b0;
              data_next  = 8'h06;
            end
            INIT_ENTRY: begin
              step_next  = SET_ADDR;
              phase_next = SETUP;
              rs_next    = 1'b0;
              data_next  = 8'h80 | row_base(row);
            end
            SET_ADDR: begin
              step_next  = WRITE_CHAR;
              phase_next = FETCH;
            end
            default: begin
              // End of a data write: advance the scan position.
              if (column != COL_LAST) begin
                column_next = column + 7'd1;
                step_next   = WRITE_CHAR;
                phase_next  = FETCH;
              end else begin
                column_next = '0;
                if (row != ROW_LAST) begin
                  row_next = row + 6'd1;
                end else begin
                  row_next        = '0;
                  frame_done_next = 1'b1;
                end
                step_next  = SET_ADDR;
                phase_next = SETUP;
                rs_next    = 1'b0;
                data_next  = 8'h80 | row_base(row_next);
              end
            end
          endcase
        end
      end
      FETCH: begin
        // column/row have been stable since the previous edge; capture now.
        count_next = '0;
        phase_next = SETUP;
        rs_next    = 1'b1;
        data_next  = {1'b0, character};
      end
      default: begin
        count_next = '0;
        phase_next = POWER_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed testbench for lcd_char_writer with small timing parameters.
module tb_lcd_char_writer;

  localparam int COLUMNS = 4;
  localparam int ROWS    = 2;
  localparam int POWER   = 20;
  localparam int SETUP   = 2;
  localparam int PULSE   = 3;
  localparam int HOLD    = 2;
  localparam int EXEC    = 5;
  localparam int CLEAR   = 12;
  localparam int FRAMES  = 3;
  localparam int NWR     = 4 + FRAMES * ROWS * (1 + COLUMNS);

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset_n;
  logic [6:0] column;
  logic [5:0] row;
  logic [6:0] character;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic       frame_done;
  logic [5:0] debug_state;
  logic       poison;

  always #5 clock = ~clock;

  lcd_char_writer #(
    .COLUMNS(COLUMNS), .ROWS(ROWS), .POWER_ON_CYCLES(POWER),
    .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE), .HOLD_CYCLES(HOLD),
    .EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLEAR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .column(column), .row(row),
    .character(character), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .frame_done(frame_done), .debug_state(debug_state)
  );

  // Character source; when poisoned it returns 7F outside FETCH (phase 5).
  assign character = (poison && debug_state[2:0] != 3'd5) ? 7'h7F
                   : ({row[0], column[5:0]} ^ 7'h40);

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [8:0] exp_q[$];
  int         exp_rise[$];
  logic [8:0] wr_q[$];
  int         rise_q[$];
  int         fd_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] base_of(input int r);
    case (r)
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'(COLUMNS);
      default: return 8'(8'h40 + COLUMNS);
    endcase
  endfunction

  // Expected writes and the cycle at which each write's E rises.
  task automatic build_model();
    int t;
    logic [6:0] ch;
    exp_q.delete();
    exp_rise.delete();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    for (int f = 0; f < FRAMES; f++)
      for (int r = 0; r < ROWS; r++) begin
        exp_q.push_back({1'b0, 8'h80 | base_of(r)});
        for (int c = 0; c < COLUMNS; c++) begin
          ch = {r[0], c[5:0]} ^ 7'h40;
          exp_q.push_back({1'b1, 1'b0, ch});
        end
      end
    t = POWER + SETUP;
    for (int i = 0; i < exp_q.size(); i++) begin
      exp_rise.push_back(t);
      if (i + 1 < exp_q.size())
        t += PULSE + HOLD + ((exp_q[i] == 9'h001) ? CLEAR : EXEC) + SETUP
           + (exp_q[i+1][8] ? 1 : 0);
    end
  endtask

  always @(posedge clock) begin
    if (!reset_n) cyc = 0;
    else          cyc = cyc + 1;
  end

  // ---------------- bus monitor ----------------
  logic [8:0] hist1, hist2, held, cur;
  logic       e_prev, fd_prev;
  int         hi_cnt, hold_left;

  always @(negedge clock) begin
    if (!reset_n) begin
      e_prev = 1'b0; fd_prev = 1'b0; hi_cnt = 0; hold_left = 0;
      hist1 = '0; hist2 = '0; held = '0;
    end else begin
      cur = {lcd_rs, lcd_data};
      if (lcd_rw !== 1'b0) chk("rw_low", {31'd0, lcd_rw}, 32'd0);
      if (lcd_e && !e_prev) begin
        chk($sformatf("setup_stable_%0d", wr_q.size()), {hist2, hist1}, {cur, cur});
        wr_q.push_back(cur);
        rise_q.push_back(cyc);
        held   = cur;
        hi_cnt = 1;
      end else if (lcd_e) begin
        if (cur !== held) chk("pulse_stable", 32'(cur), 32'(held));
        hi_cnt++;
      end else if (e_prev) begin
        chk($sformatf("e_high_len_%0d", wr_q.size()), 32'(hi_cnt), PULSE);
        chk($sformatf("hold1_stable_%0d", wr_q.size()), 32'(cur), 32'(held));
        hold_left = HOLD - 1;
      end else if (hold_left > 0) begin
        chk($sformatf("hold_stable_%0d", wr_q.size()), 32'(cur), 32'(held));
        hold_left--;
      end
      if (frame_done) begin
        chk("fd_one_cycle", {31'd0, fd_prev}, 32'd0);
        fd_q.push_back(cyc);
      end
      hist2   = hist1;
      hist1   = cur;
      e_prev  = lcd_e;
      fd_prev = frame_done;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    build_model();
    poison  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);

    // Reset values.
    chk("rst_e",     {31'd0, lcd_e}, 32'd0);
    chk("rst_rs",    {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw",    {31'd0, lcd_rw}, 32'd0);
    chk("rst_data",  32'(lcd_data), 32'h00);
    chk("rst_col",   32'(column), 32'd0);
    chk("rst_row",   32'(row), 32'd0);
    chk("rst_fd",    {31'd0, frame_done}, 32'd0);
    chk("rst_state", 32'(debug_state), 32'd0);

    // First frame with an honest source.
    reset_n = 1'b1;
    for (int i = 0; i < 1000 && fd_q.size() < 1; i++) @(negedge clock);
    chk("frame1_done_seen", 32'(fd_q.size()), 32'd1);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("f1_write_%0d", i), 32'(wr_q[i]), 32'(exp_q[i]));
      chk($sformatf("f1_rise_%0d", i), 32'(rise_q[i]), 32'(exp_rise[i]));
    end
    chk("f1_fd_cycle", 32'(fd_q[0]), 32'(exp_rise[13] + PULSE + HOLD + EXEC));
    chk("f1_fd_col", 32'(column), 32'd0);
    chk("f1_fd_row", 32'(row), 32'd0);

    // Reset in the middle of the E pulse of frame 2's second data write.
    for (int i = 0; i < 200 && wr_q.size() < 17; i++) @(negedge clock);
    chk("f2_third_write", 32'(wr_q[16]), 32'(exp_q[16]));
    chk("f2_col_before_rst", 32'(column), 32'd1);
    @(negedge clock);
    chk("f2_e_before_rst", {31'd0, lcd_e}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_e",    {31'd0, lcd_e}, 32'd0);
    chk("arst_rs",   {31'd0, lcd_rs}, 32'd0);
    chk("arst_data", 32'(lcd_data), 32'h00);
    chk("arst_col",  32'(column), 32'd0);
    chk("arst_row",  32'(row), 32'd0);
    repeat (2) @(negedge clock);
    wr_q.delete();
    rise_q.delete();
    fd_q.delete();

    // Full init again, three frames, source returns 7F outside FETCH.
    poison  = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 3000 && fd_q.size() < FRAMES; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    chk("fd_count", 32'(fd_q.size()), FRAMES);
    chk("write_count_min", 32'(wr_q.size() >= NWR), 32'd1);
    for (int i = 0; i < NWR; i++) begin
      chk($sformatf("run2_write_%0d", i), 32'(wr_q[i]), 32'(exp_q[i]));
      chk($sformatf("run2_rise_%0d", i), 32'(rise_q[i]), 32'(exp_rise[i]));
    end
    for (int k = 0; k < FRAMES; k++)
      chk($sformatf("run2_fd_cycle_%0d", k), 32'(fd_q[k]),
          32'(exp_rise[4 + (k + 1) * ROWS * (1 + COLUMNS) - 1] + PULSE + HOLD + EXEC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
